// File: rtl/data_writer.sv
// rtl/data_writer.sv - burst writer: streams a counted burst of words into an internal memory with an independent read port
//
// Purpose:
//   An IDLE/RUN/DONE FSM accepts a start request with a burst length.
//   In RUN it takes words over a valid/ready handshake and writes them to
//   consecutive addresses starting at 0. A separate registered read port
//   (1-cycle latency, read-first on collision) gives access to the memory.
//
// Optional feature:
//   DATA_WRITER_ABORT_EN - adds abort_i, which ends a burst early from RUN
//                          straight back to IDLE without entering DONE.
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-high reset
//   abort_i     in   burst abort (only with DATA_WRITER_ABORT_EN)
//   start_i     in   burst request, sampled in IDLE
//   cnt_val_i   in   burst length in words, sampled with start_i
//   s_valid_i   in   input word valid
//   s_data_i    in   input word
//   s_ready_o   out  block accepts a word this cycle (RUN)
//   rd_en_i     in   read enable
//   rd_addr_i   in   read address
//   rd_data_o   out  registered read data
//   idle_o      out  FSM in IDLE
//   run_o       out  FSM in RUN
//   done_o      out  FSM in DONE (one cycle)
//   wr_cnt_o    out  words written in the current/last burst

module data_writer #(
    parameter int DWIDTH   = 32,
    parameter int AWIDTH   = 7,
    parameter int MEM_SIZE = 100
) (
    input  logic              clk,
    input  logic              rst,
`ifdef DATA_WRITER_ABORT_EN
    input  logic              abort_i,
`endif
    input  logic              start_i,
    input  logic [AWIDTH-1:0] cnt_val_i,
    input  logic              s_valid_i,
    input  logic [DWIDTH-1:0] s_data_i,
    output logic              s_ready_o,
    input  logic              rd_en_i,
    input  logic [AWIDTH-1:0] rd_addr_i,
    output logic [DWIDTH-1:0] rd_data_o,
    output logic              idle_o,
    output logic              run_o,
    output logic              done_o,
    output logic [AWIDTH-1:0] wr_cnt_o
);

    localparam logic [31:0] MEM_SIZE_U = 32'(MEM_SIZE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [AWIDTH-1:0]   len_q, len_d;
    logic [AWIDTH-1:0]   wr_cnt_q, wr_cnt_d;
    logic [DWIDTH-1:0]   rd_data_q;
    logic                wr_en;
    logic                abort_w;
    logic                wr_in_range;
    logic                rd_in_range;
    logic [AWIDTH-1:0]   len_clamped;

    logic [DWIDTH-1:0]   mem [MEM_SIZE];

`ifdef DATA_WRITER_ABORT_EN
    assign abort_w = abort_i && (state_q == S_RUN);
`else
    assign abort_w = 1'b0;
`endif

    // Burst length is clamped to the memory depth so the write pointer
    // can never run past the last word.
    assign len_clamped = (32'(cnt_val_i) > MEM_SIZE_U) ? AWIDTH'(MEM_SIZE_U) : cnt_val_i;

    assign wr_in_range = (32'(wr_cnt_q) < MEM_SIZE_U);
    assign rd_in_range = (32'(rd_addr_i) < MEM_SIZE_U);

    // State register and burst bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            len_q    <= '0;
            wr_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        wr_cnt_d = wr_cnt_q;
        wr_en    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i && (cnt_val_i != '0)) begin
                    len_d    = len_clamped;
                    wr_cnt_d = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (abort_w) begin
                    // Abort wins over a same-cycle handshake: no write.
                    state_d = S_IDLE;
                end else if (s_valid_i) begin
                    wr_en    = wr_in_range;
                    wr_cnt_d = wr_cnt_q + 1'b1;
                    if (wr_cnt_q == (len_q - 1'b1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Memory write port; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_cnt_q] <= s_data_i;
        end
    end

    // Read port. Non-blocking update on both ports gives read-first
    // behaviour when the addresses collide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= rd_in_range ? mem[rd_addr_i] : '0;
        end
    end

    assign idle_o    = (state_q == S_IDLE);
    assign run_o     = (state_q == S_RUN);
    assign done_o    = (state_q == S_DONE);
    assign s_ready_o = (state_q == S_RUN);
    assign wr_cnt_o  = wr_cnt_q;
    assign rd_data_o = rd_data_q;

endmodule

// File: doc/data_writer.md
DATA_WRITER -- requirements
Module: data_writer

Interface
REQ-001 Parameter DWIDTH, default 32, SHALL set the data word width.
REQ-002 Parameter AWIDTH, default 7, SHALL set the address and count width.
REQ-003 Parameter MEM_SIZE, default 100, SHALL set the internal memory depth in words.
REQ-004 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-006 start_i  input  1  SHALL request a write burst; it is sampled only in IDLE.
REQ-007 cnt_val_i  input  AWIDTH  SHALL give the burst length in words; it is sampled with start_i.
REQ-008 s_valid_i  input  1  SHALL flag that s_data_i holds a valid word.
REQ-009 s_data_i  input  DWIDTH  SHALL carry the word to be written.
REQ-010 s_ready_o  output  1  SHALL flag that the block accepts a word this cycle.
REQ-011 rd_en_i  input  1  SHALL be the read-port enable.
REQ-012 rd_addr_i  input  AWIDTH  SHALL be the read-port address.
REQ-013 rd_data_o  output  DWIDTH  SHALL be the registered read data.
REQ-014 idle_o / run_o / done_o  output  1 each  SHALL give the FSM state, one-hot.
REQ-015 wr_cnt_o  output  AWIDTH  SHALL give the number of words written in the current burst.

Function
REQ-016 The block SHALL contain a MEM_SIZE x DWIDTH memory with one write port, driven by the FSM, and one independent read port.
REQ-017 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-018 In IDLE, start_i=1 with cnt_val_i!=0 SHALL latch len = min(cnt_val_i, MEM_SIZE), clear wr_cnt to 0 and enter RUN on the next cycle.
REQ-019 In IDLE, start_i=1 with cnt_val_i=0 SHALL be ignored, and the FSM SHALL stay in IDLE.
REQ-020 s_ready_o SHALL be 1 exactly when the FSM is in RUN.
REQ-021 When s_valid_i and s_ready_o are both 1, the block SHALL write s_data_i to address wr_cnt at that edge and SHALL increment wr_cnt.
REQ-022 When s_valid_i=0 in RUN, the block SHALL hold its state with no write, for any number of cycles.
REQ-023 The handshake on word wr_cnt=len-1 SHALL move the FSM to DONE.
REQ-024 DONE SHALL last exactly one cycle, with done_o=1, and the FSM SHALL then return to IDLE.
REQ-025 start_i SHALL be ignored in RUN and in DONE.
REQ-026 wr_cnt_o SHALL hold the final count through DONE and IDLE until the next accepted start_i.
REQ-027 rd_en_i=1 SHALL load mem[rd_addr_i] into rd_data_o on the next edge, giving a 1-cycle latency.
REQ-028 When rd_en_i=0, rd_data_o SHALL hold its value.
REQ-029 A read and a write to the same address in the same cycle SHALL return the old data (read-first).
REQ-030 A read with rd_addr_i >= MEM_SIZE SHALL return 0, and a write SHALL never target an address >= MEM_SIZE.

Reset
REQ-031 rst=1 SHALL immediately force IDLE, idle_o=1, run_o=0, done_o=0, s_ready_o=0, wr_cnt_o=0, rd_data_o=0 and len=0.
REQ-032 Memory contents SHALL NOT be reset.
REQ-033 A reset during RUN SHALL abandon the burst, keep the words already written, and leave the block ready for start_i on the first edge after rst falls.

Configuration
REQ-034 With the macro DATA_WRITER_ABORT_EN defined, the block SHALL add the port abort_i (input, 1 bit).
REQ-035 With DATA_WRITER_ABORT_EN defined, abort_i=1 in RUN SHALL suppress that cycle's write and return the FSM to IDLE on the next edge without entering DONE; wr_cnt_o SHALL keep the count of words written.
REQ-036 With DATA_WRITER_ABORT_EN defined, abort_i SHALL be ignored outside RUN.
REQ-037 Without DATA_WRITER_ABORT_EN, the abort_i port SHALL NOT exist, and every burst SHALL end only through DONE or reset.

Verification
REQ-038 Basic burst: start_i with cnt_val_i=4, then s_valid_i held high with data 0xA0..0xA3 -> four writes in consecutive cycles, done_o high for 1 cycle, wr_cnt_o=4, reads of addresses 0..3 return 0xA0..0xA3 one cycle after rd_en_i.
REQ-039 Back-pressure gaps: cnt_val_i=3, with s_valid_i toggled 1,0,0,1,0,1 -> exactly 3 writes at addresses 0,1,2, and DONE in the cycle after the third handshake.
REQ-040 Boundaries: cnt_val_i=0 -> FSM stays in IDLE; cnt_val_i=120 with MEM_SIZE=100 -> exactly 100 writes (addresses 0..99), wr_cnt_o=100, then DONE.
REQ-041 Collision: read and write both at address 2 in the same cycle (old value 0x11, new value 0x22) -> rd_data_o=0x11 that cycle, then 0x22 on a re-read.
REQ-042 Reset in RUN: rst asserted after 2 of 5 words -> outputs reach reset values with no clock edge, addresses 0..1 keep their data, and a new start_i is accepted right after release.
REQ-043 Abort (DATA_WRITER_ABORT_EN defined): abort_i=1 together with the 3rd handshake of an 8-word burst -> no write to address 2, FSM goes to IDLE with done_o never high, wr_cnt_o=2.
